// File: rtl/bmp_row_packer.sv
// bmp_row_packer
// Takes pixels from a first-word-fall-through FIFO and turns each one into
// NUM_CHANNELS identical bytes (the top 8 bits of the pixel). At the end of
// each row it adds 0x00 bytes so that the row length is a multiple of 4,
// as BMP requires. It tracks the pixel column and the row, and raises
// frame_done for one cycle after the last byte of a frame.
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-low; clears all state while low
//   in_dout     head of the upstream FIFO, valid while in_empty=0
//   in_empty    upstream FIFO is empty
//   in_rd_en    pops the upstream FIFO on this clock edge
//   out_din     byte for the downstream FIFO
//   out_full    downstream FIFO is full
//   out_wr_en   writes out_din on this clock edge
//   col, row    current pixel column and row
//   frame_done  one-cycle pulse after the last byte of a frame
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | wait for a pixel, pop it and latch it
// EMIT    | write NUM_CHANNELS copies of the latched pixel's top byte
// PAD     | write the 0x00 bytes that pad the row
// ROW_END | one idle cycle: move to the next row, or end the frame
// DONE    | one cycle with frame_done high
module bmp_row_packer #(
  parameter int IMG_WIDTH    = 720,
  parameter int IMG_HEIGHT   = 540,
  parameter int DWIDTH       = 8,
  parameter int NUM_CHANNELS = 3,
  parameter int PAD_ROWS     = 1,
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1,
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DWIDTH-1:0] in_dout,
  input  logic              in_empty,
  output logic              in_rd_en,
  output logic [7:0]        out_din,
  input  logic              out_full,
  output logic              out_wr_en,
  output logic [CW-1:0]     col,
  output logic [RW-1:0]     row,
  output logic              frame_done
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_EMIT    = 3'd1;
  localparam logic [2:0] S_PAD     = 3'd2;
  localparam logic [2:0] S_ROW_END = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Number of zero bytes needed to bring a row up to a multiple of 4 bytes.
  localparam int PAD = (PAD_ROWS != 0) ? (4 - (IMG_WIDTH * NUM_CHANNELS) % 4) % 4 : 0;
  localparam int LAST_PAD_I = (PAD > 0) ? PAD - 1 : 0;

  localparam logic [1:0]    LAST_CH  = 2'(NUM_CHANNELS - 1);
  localparam logic [1:0]    LAST_PAD = 2'(LAST_PAD_I);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [1:0]        chan_q, chan_d;
  logic [1:0]        pad_q, pad_d;
  logic [DWIDTH-1:0] pix_q, pix_d;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    chan_d  = chan_q;
    pad_d   = pad_q;
    pix_d   = pix_q;

    // The strobes are gated by reset so the FIFOs are left alone while
    // the block is held in reset.
    in_rd_en   = reset && (state_q == S_FETCH) && !in_empty;
    out_wr_en  = reset && ((state_q == S_EMIT) || (state_q == S_PAD)) && !out_full;
    out_din    = (state_q == S_EMIT) ? pix_q[DWIDTH-1 -: 8] : 8'h00;
    frame_done = (state_q == S_DONE);

    case (state_q)
      S_FETCH: begin
        if (!in_empty) begin
          pix_d   = in_dout;
          chan_d  = 2'd0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (!out_full) begin
          if (chan_q == LAST_CH) begin
            chan_d = 2'd0;
            if (col_q != LAST_COL) begin
              col_d   = col_q + 1'b1;
              state_d = S_FETCH;
            end else if (PAD > 0) begin
              pad_d   = 2'd0;
              state_d = S_PAD;
            end else begin
              state_d = S_ROW_END;
            end
          end else begin
            chan_d = chan_q + 2'd1;
          end
        end
      end
      S_PAD: begin
        if (!out_full) begin
          if (pad_q == LAST_PAD) state_d = S_ROW_END;
          else                   pad_d   = pad_q + 2'd1;
        end
      end
      S_ROW_END: begin
        col_d = '0;
        if (row_q != LAST_ROW) begin
          row_d   = row_q + 1'b1;
          state_d = S_FETCH;
        end else begin
          row_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      col_q   <= '0;
      row_q   <= '0;
      chan_q  <= 2'd0;
      pad_q   <= 2'd0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      chan_q  <= chan_d;
      pad_q   <= pad_d;
      pix_q   <= pix_d;
    end
  end

  assign col = col_q;
  assign row = row_q;

endmodule

// File: tb/tb_bmp_row_packer.sv
module tb_bmp_row_packer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // ---------------- instance A: 64x32, NC=3, 8-bit, no pad ----------------
  logic       reset_a = 1'b0;
  logic [7:0] din_a;
  logic       empty_a, rden_a, wren_a, fd_a;
  logic       full_a = 1'b0;
  logic       gap_a = 1'b0;
  logic [7:0] dout_a;
  logic [5:0] col_a;
  logic [4:0] row_a;
  logic [7:0] src_a [0:8191];
  logic [7:0] cap_a [0:32767];
  int n_a = 0, rp_a = 0, nw_a = 0, nfd_a = 0, lastwr_a = 0, fdcyc_a = 0, both_a = 0, fullrd_a = 0;

  assign din_a   = src_a[rp_a[12:0]];
  assign empty_a = (rp_a >= n_a) || gap_a;

  always @(posedge clock) begin
    if (rden_a) rp_a <= rp_a + 1;
    if (wren_a) begin cap_a[nw_a[14:0]] <= dout_a; nw_a <= nw_a + 1; lastwr_a <= cyc; end
    if (fd_a) begin nfd_a <= nfd_a + 1; fdcyc_a <= cyc; end
    if (rden_a && wren_a) both_a <= both_a + 1;
    if (rden_a && full_a) fullrd_a <= fullrd_a + 1;
  end

  bmp_row_packer #(.IMG_WIDTH(64), .IMG_HEIGHT(32), .DWIDTH(8), .NUM_CHANNELS(3), .PAD_ROWS(1)) u_a (
    .clock(clock), .reset(reset_a), .in_dout(din_a), .in_empty(empty_a), .in_rd_en(rden_a),
    .out_din(dout_a), .out_full(full_a), .out_wr_en(wren_a), .col(col_a), .row(row_a),
    .frame_done(fd_a));

  // ---------------- instance B: 5x2, NC=3, 10-bit, pad=1 ----------------
  logic       reset_b = 1'b0;
  logic [9:0] din_b;
  logic       empty_b, rden_b, wren_b, fd_b;
  logic       full_b = 1'b0;
  logic [7:0] dout_b;
  logic [2:0] col_b;
  logic [0:0] row_b;
  logic [9:0] src_b [0:63];
  logic [7:0] cap_b [0:127];
  int n_b = 0, rp_b = 0, nw_b = 0, nfd_b = 0, lastwr_b = 0, fdcyc_b = 0, both_b = 0;

  assign din_b   = src_b[rp_b[5:0]];
  assign empty_b = (rp_b >= n_b);

  always @(posedge clock) begin
    if (rden_b) rp_b <= rp_b + 1;
    if (wren_b) begin cap_b[nw_b[6:0]] <= dout_b; nw_b <= nw_b + 1; lastwr_b <= cyc; end
    if (fd_b) begin nfd_b <= nfd_b + 1; fdcyc_b <= cyc; end
    if (rden_b && wren_b) both_b <= both_b + 1;
  end

  bmp_row_packer #(.IMG_WIDTH(5), .IMG_HEIGHT(2), .DWIDTH(10), .NUM_CHANNELS(3), .PAD_ROWS(1)) u_b (
    .clock(clock), .reset(reset_b), .in_dout(din_b), .in_empty(empty_b), .in_rd_en(rden_b),
    .out_din(dout_b), .out_full(full_b), .out_wr_en(wren_b), .col(col_b), .row(row_b),
    .frame_done(fd_b));

  // ---------------- instance C: 5x2, NC=3, 8-bit, padding disabled ----------------
  logic       reset_c = 1'b0;
  logic [7:0] din_c;
  logic       empty_c, rden_c, wren_c, fd_c;
  logic       full_c = 1'b0;
  logic [7:0] dout_c;
  logic [2:0] col_c;
  logic [0:0] row_c;
  logic [7:0] src_c [0:63];
  logic [7:0] cap_c [0:127];
  int n_c = 0, rp_c = 0, nw_c = 0, nfd_c = 0, lastwr_c = 0, fdcyc_c = 0, fdprev_c = 0, both_c = 0;

  assign din_c   = src_c[rp_c[5:0]];
  assign empty_c = (rp_c >= n_c);

  always @(posedge clock) begin
    if (rden_c) rp_c <= rp_c + 1;
    if (wren_c) begin cap_c[nw_c[6:0]] <= dout_c; nw_c <= nw_c + 1; lastwr_c <= cyc; end
    if (fd_c) begin nfd_c <= nfd_c + 1; fdcyc_c <= cyc; fdprev_c <= fdcyc_c; end
    if (rden_c && wren_c) both_c <= both_c + 1;
  end

  bmp_row_packer #(.IMG_WIDTH(5), .IMG_HEIGHT(2), .DWIDTH(8), .NUM_CHANNELS(3), .PAD_ROWS(0)) u_c (
    .clock(clock), .reset(reset_c), .in_dout(din_c), .in_empty(empty_c), .in_rd_en(rden_c),
    .out_din(dout_c), .out_full(full_c), .out_wr_en(wren_c), .col(col_c), .row(row_c),
    .frame_done(fd_c));

  // ---------------------------------------------------------------------------

  task automatic test_reset();
    logic [9:0] pv [10] = '{10'h3FF, 10'h004, 10'h155, 10'h2AA, 10'h0FC,
                            10'h001, 10'h3FC, 10'h200, 10'h0FF, 10'h1FE};
    for (int k = 0; k < 2048; k++) src_a[k] = 8'(k);
    n_a = 2048;
    for (int k = 0; k < 10; k++) src_b[k] = pv[k];
    n_b = 10;
    for (int k = 0; k < 20; k++) src_c[k] = 8'(8'h10 + k * 3);
    n_c = 20;
    repeat (3) @(negedge clock);
    tests++;
    if ({col_a, row_a, rden_a, wren_a, fd_a, dout_a} !== '0) begin
      fails++;
      $display("FAIL reset_a: col=%0d row=%0d rd=%b wr=%b fd=%b din=%h, expected all 0",
               col_a, row_a, rden_a, wren_a, fd_a, dout_a);
    end
    tests++;
    if ({col_b, row_b, rden_b, wren_b, fd_b, dout_b, col_c, row_c, rden_c, wren_c, fd_c, dout_c} !== '0) begin
      fails++;
      $display("FAIL reset_bc: rd_b=%b wr_b=%b rd_c=%b wr_c=%b, expected all 0", rden_b, wren_b, rden_c, wren_c);
    end
    tests++;
    if (rp_a + rp_b + rp_c !== 0) begin
      fails++;
      $display("FAIL reset_no_pop: pops=%0d expected 0", rp_a + rp_b + rp_c);
    end
    reset_a = 1'b1;
    reset_b = 1'b1;
    reset_c = 1'b1;
  endtask

  task automatic test_ramp();
    int bad = 0;
    int i;
    for (i = 0; i < 20000 && nfd_a < 1; i++) @(negedge clock);
    tests++;
    if (nfd_a < 1) begin fails++; $display("FAIL ramp_timeout: frame_done count=%0d expected 1", nfd_a); end
    repeat (5) @(negedge clock);
    tests++;
    if (nw_a !== 6144) begin fails++; $display("FAIL ramp_bytes: got %0d expected 6144", nw_a); end
    for (int j = 0; j < 6144; j++) if (cap_a[15'(j)] !== 8'(j / 3)) bad++;
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL ramp_data: %0d wrong bytes, expected 0", bad); end
    tests++;
    if (nfd_a !== 1) begin fails++; $display("FAIL ramp_fd_count: got %0d expected 1", nfd_a); end
    tests++;
    if (fdcyc_a - lastwr_a !== 2) begin
      fails++; $display("FAIL ramp_fd_timing: got %0d cycles after last byte, expected 2", fdcyc_a - lastwr_a);
    end
  endtask

  task automatic test_pad_dw10();
    logic [7:0] t [10] = '{8'hFF, 8'h01, 8'h55, 8'hAA, 8'h3F, 8'h00, 8'hFF, 8'h80, 8'h3F, 8'h7F};
    logic [7:0] exp_b [32];
    int bad = 0;
    int idx = 0;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 5; p++) for (int c = 0; c < 3; c++) begin exp_b[idx] = t[r * 5 + p]; idx++; end
      exp_b[idx] = 8'h00; idx++;
    end
    for (int i = 0; i < 500 && nfd_b < 1; i++) @(negedge clock);
    repeat (5) @(negedge clock);
    tests++;
    if (nw_b !== 32) begin fails++; $display("FAIL pad_bytes: got %0d expected 32", nw_b); end
    for (int j = 0; j < 32; j++) if (cap_b[7'(j)] !== exp_b[j]) bad++;
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL pad_data: %0d wrong bytes, expected 0", bad); end
    tests++;
    if (cap_b[0] !== 8'hFF || cap_b[3] !== 8'h01) begin
      fails++; $display("FAIL dw10_msb: got %h %h expected ff 01", cap_b[0], cap_b[3]);
    end
    tests++;
    if (cap_b[15] !== 8'h00 || cap_b[31] !== 8'h00) begin
      fails++; $display("FAIL pad_zero: got %h %h expected 00 00", cap_b[15], cap_b[31]);
    end
    tests++;
    if (nfd_b !== 1 || fdcyc_b - lastwr_b !== 2) begin
      fails++; $display("FAIL pad_fd: count=%0d gap=%0d expected 1 and 2", nfd_b, fdcyc_b - lastwr_b);
    end
    tests++;
    if (both_b !== 0) begin fails++; $display("FAIL pad_rd_wr_overlap: got %0d expected 0", both_b); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    int zeros = 0;
    for (int i = 0; i < 500 && nfd_c < 2; i++) @(negedge clock);
    repeat (5) @(negedge clock);
    tests++;
    if (nw_c !== 60) begin fails++; $display("FAIL nopad_bytes: got %0d expected 60", nw_c); end
    for (int j = 0; j < 60; j++) begin
      if (cap_c[7'(j)] !== 8'(8'h10 + (j / 3) * 3)) bad++;
      if (cap_c[7'(j)] === 8'h00) zeros++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL nopad_data: %0d wrong bytes, expected 0", bad); end
    tests++;
    if (zeros !== 0) begin fails++; $display("FAIL nopad_zero_bytes: got %0d expected 0", zeros); end
    tests++;
    if (nfd_c !== 2) begin fails++; $display("FAIL b2b_fd_count: got %0d expected 2", nfd_c); end
    // 10 pixels * 4 cycles + 2 row-end cycles + 1 done cycle
    tests++;
    if (fdcyc_c - fdprev_c !== 43) begin
      fails++; $display("FAIL b2b_frame_period: got %0d expected 43", fdcyc_c - fdprev_c);
    end
    tests++;
    if (fdcyc_c - lastwr_c !== 2 || both_c !== 0) begin
      fails++; $display("FAIL b2b_fd_timing: gap=%0d overlap=%0d expected 2 and 0", fdcyc_c - lastwr_c, both_c);
    end
  endtask

  task automatic test_stall();
    int w0 = nw_a;
    int fd0 = nfd_a;
    int bad = 0;
    int ws;
    bit stalled = 0, stall_bad = 0, done = 0;
    logic [5:0] c0;
    for (int k = 0; k < 2048; k++) src_a[13'(n_a + k)] = 8'(k * 7 + 3);
    n_a = n_a + 2048;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clock);
      if (nfd_a > fd0) done = 1;
      else if (!stalled && nw_a - w0 >= 300 && wren_a) begin
        stalled = 1;
        gap_a = 1'b0;
        full_a = 1'b1;
        c0 = col_a;
        ws = nw_a;
        #1;
        if (wren_a !== 1'b0 || rden_a !== 1'b0) stall_bad = 1;
        for (int k = 0; k < 7; k++) begin
          @(negedge clock);
          if (wren_a !== 1'b0 || rden_a !== 1'b0 || col_a !== c0 || nw_a !== ws) stall_bad = 1;
        end
        full_a = 1'b0;
      end else gap_a = ($urandom_range(0, 3) == 0);
    end
    gap_a = 1'b0;
    repeat (5) @(negedge clock);
    tests++;
    if (!done) begin fails++; $display("FAIL stall_timeout: frame_done count=%0d expected %0d", nfd_a, fd0 + 1); end
    tests++;
    if (!stalled || stall_bad) begin fails++; $display("FAIL stall_hold: stalled=%b bad=%b expected 1 0", stalled, stall_bad); end
    tests++;
    if (nw_a - w0 !== 6144) begin fails++; $display("FAIL stall_bytes: got %0d expected 6144", nw_a - w0); end
    for (int j = 0; j < 6144; j++) if (cap_a[15'(w0 + j)] !== 8'((j / 3) * 7 + 3)) bad++;
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL stall_data: %0d wrong bytes, expected 0", bad); end
    tests++;
    if (fullrd_a !== 0 || both_a !== 0) begin
      fails++; $display("FAIL stall_rd_en: rd-while-full=%0d overlap=%0d expected 0 0", fullrd_a, both_a);
    end
    tests++;
    if (nfd_a - fd0 !== 1) begin fails++; $display("FAIL stall_fd_count: got %0d expected 1", nfd_a - fd0); end
  endtask

  task automatic test_async_reset();
    int rel, w0, fd0, rp0;
    int bad = 0;
    bit found = 0;
    for (int k = 0; k < 2048; k++) src_a[13'(n_a + k)] = 8'(k) ^ 8'h5A;
    n_a = n_a + 2048;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clock);
      if (col_a == 6'd3 && row_a == 5'd1) found = 1;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL areset_reach: col=%0d row=%0d expected 3 1", col_a, row_a); end
    #2;
    reset_a = 1'b0;
    #1;
    tests++;
    if ({col_a, row_a, rden_a, wren_a, fd_a, dout_a} !== '0) begin
      fails++;
      $display("FAIL areset_outputs: col=%0d row=%0d rd=%b wr=%b fd=%b din=%h expected all 0",
               col_a, row_a, rden_a, wren_a, fd_a, dout_a);
    end
    rp0 = rp_a;
    repeat (2) @(negedge clock);
    tests++;
    if (rp_a !== rp0) begin fails++; $display("FAIL areset_no_pop: pops=%0d expected 0", rp_a - rp0); end
    rel = rp_a;
    w0 = nw_a;
    fd0 = nfd_a;
    for (int j = n_a; j < rel + 2048; j++) src_a[13'(j)] = 8'(j * 5);
    if (rel + 2048 > n_a) n_a = rel + 2048;
    reset_a = 1'b1;
    for (int i = 0; i < 20000 && nfd_a == fd0; i++) @(negedge clock);
    repeat (5) @(negedge clock);
    tests++;
    if (nw_a - w0 !== 6144) begin fails++; $display("FAIL areset_bytes: got %0d expected 6144", nw_a - w0); end
    for (int j = 0; j < 6144; j++) if (cap_a[15'(w0 + j)] !== src_a[13'(rel + j / 3)]) bad++;
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL areset_data: %0d wrong bytes, expected 0", bad); end
    tests++;
    if (nfd_a - fd0 !== 1 || fdcyc_a - lastwr_a !== 2) begin
      fails++; $display("FAIL areset_fd: count=%0d gap=%0d expected 1 and 2", nfd_a - fd0, fdcyc_a - lastwr_a);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_pad_dw10();
    test_back_to_back();
    test_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bmp_row_packer.md
Name: bmp_row_packer

Overview:
- Parametrised successor to the fixed grayscale-to-BMP output stage of the image pipeline.
- Sits after the last filter FIFO (grayscale, gaussian or sobel), in place of the bench's ad hoc 3x-replicate-and-write loop.
- Pops DWIDTH-wide pixels from an upstream FWFT FIFO, expands each to NUM_CHANNELS output bytes, and inserts BMP row padding so every row is a multiple of 4 bytes.
- Writes bytes to a downstream byte FIFO, counts rows and columns, and flags end of frame.

Parameters:
- IMG_WIDTH, 720, pixels per row (>=1)
- IMG_HEIGHT, 540, rows per frame (>=1)
- DWIDTH, 8, input pixel width (>=8); the top 8 bits are emitted
- NUM_CHANNELS, 3, bytes emitted per pixel (1..4), all carrying the same value
- PAD_ROWS, 1, 1 inserts 0x00 pad bytes at row end; 0 disables padding

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state when 0
- in_dout  in  DWIDTH  head of upstream FIFO, valid while in_empty=0
- in_empty  in  1  upstream FIFO empty
- in_rd_en  out  1  pops upstream FIFO on a clock edge
- out_din  out  8  byte to downstream FIFO
- out_full  in  1  downstream FIFO full
- out_wr_en  out  1  writes out_din on a clock edge
- col  out  clog2(IMG_WIDTH)  current pixel column
- row  out  clog2(IMG_HEIGHT)  current row
- frame_done  out  1  one-cycle pulse after the last byte of a frame

Behaviour:
- Reset (reset=0):
  - state=FETCH; col=row=0; channel counter=0; pad counter=0.
  - Pixel latch=0; out_wr_en=0; in_rd_en=0; frame_done=0.
  - Taking effect mid-frame discards the latched pixel and partial row; the next frame restarts at col 0, row 0.
- Padding count:
  - PAD = PAD_ROWS ? (4 - (IMG_WIDTH*NUM_CHANNELS) mod 4) mod 4 : 0, computed at elaboration.
- Input FIFO is first-word-fall-through.
- in_rd_en = (state==FETCH) and !in_empty (combinational).
- out_wr_en = (state==EMIT or PAD) and !out_full (combinational).
- out_din = pixel latch[DWIDTH-1:DWIDTH-8] in EMIT, 0x00 in PAD, 0x00 otherwise.
- FSM:
  - FETCH: if !in_empty, latch in_dout, set channel=0, go to EMIT. Otherwise stay.
  - EMIT: on each cycle with !out_full, channel++. After the write with channel==NUM_CHANNELS-1:
    - if col<IMG_WIDTH-1: col++ and go to FETCH;
    - else if PAD>0: go to PAD with pad counter=0;
    - else go to ROW_END.
  - PAD: on each cycle with !out_full, pad counter++. After PAD writes, go to ROW_END.
  - ROW_END (1 cycle, no writes): col=0.
    - If row<IMG_HEIGHT-1: row++ and go to FETCH.
    - Else row=0 and go to DONE.
  - DONE (1 cycle): frame_done=1, then go to FETCH for the next frame.
- out_full stalls EMIT/PAD with no state change and no lost bytes. in_empty stalls FETCH only.
- in_rd_en and out_wr_en are never high in the same cycle.
- Throughput: one pixel per NUM_CHANNELS+1 cycles with no stalls, plus PAD+1 cycles per row, plus 1 cycle per frame.
- Latency: first byte is written on the cycle after the pop.
- Bytes per frame = IMG_HEIGHT*(IMG_WIDTH*NUM_CHANNELS+PAD).

Test Plan:
- W=64,H=32,NC=3, continuous 0x00..0xFF ramp, out never full -> 6144 bytes; each pixel appears as 3 identical bytes; no pad; frame_done pulses once, on the cycle after ROW_END of row 31.
- W=5,H=2,NC=3,PAD_ROWS=1 -> PAD=1; per-row byte stream is p0 p0 p0 ... p4 p4 p4 0x00; 32 bytes total.
- W=5,H=2,PAD_ROWS=0 -> 30 bytes, no 0x00 insertions.
- DWIDTH=10, in_dout=10'h3FF then 10'h004 -> bytes 0xFF and 0x01.
- out_full held high for 7 cycles mid-EMIT, random in_empty gaps -> byte stream identical to the unstalled run; in_rd_en never high while out_full=1 in EMIT.
- reset=0 pulsed at col 3, row 1, asynchronously between edges -> outputs go to reset values immediately; a following full frame yields the exact expected byte count and one frame_done.
